hyperbus_wb_bridge: RTL and testbench
=====================================

Name: hyperbus_wb_bridge

Overview:
Wishbone B4 classic slave that converts single-beat CPU/DMA bus cycles into the user-side request interface of the Hyperbus dual-port FIFO block. It sits directly upstream of that block in the user clock domain. It drives read/write requests, address, data and byte mask, and returns the read data or write acknowledge to the bus master. It also provides address-window decode, alignment checking and a response timeout.

Parameters:
DATA_WIDTH, 32, Wishbone and FIFO data width in bits (multiple of 16).
ADDR_WIDTH, 32, Wishbone byte address width and FIFO address width.
BASE_ADDR, 32'h0000_0000, byte address of the first Hyperbus byte in the Wishbone map.
SIZE_BYTES, 32'h0080_0000, size of the decoded window in bytes (8 MiB).
TIMEOUT_CYCLES, 1024, clk cycles to wait for a downstream response; 0 disables the timeout; maximum 65535.

Ports:
clk  in  1  user clock
rst  in  1  synchronous active-high reset
wb_adr_i  in  ADDR_WIDTH  byte address
wb_dat_i  in  DATA_WIDTH  write data
wb_sel_i  in  DATA_WIDTH/8  byte selects (1 = byte written)
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  DATA_WIDTH  read data
wb_ack_o  out  1  transfer acknowledge
wb_err_o  out  1  transfer error
rrq  out  1  read request pulse to FIFO block
wrq  out  1  write request pulse to FIFO block
adr_o  out  ADDR_WIDTH  16-bit-word address to FIFO block
tx_dat_o  out  DATA_WIDTH  write data to FIFO block
tx_mask_o  out  DATA_WIDTH/8  byte mask to FIFO block (1 = byte NOT written)
tx_ready  in  1  write-complete pulse from FIFO block
rx_dat_i  in  DATA_WIDTH  read data from FIFO block
rx_valid  in  1  read-data-valid pulse from FIFO block
busy  out  1  high whenever state != IDLE
timeout_o  out  1  one-cycle pulse on response timeout

Behaviour:
- Clock and reset: all logic runs on clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0. State = IDLE. Timeout counter = 0.
- States: IDLE, READ, WRITE, ACK, ERR, DRAIN.
- IDLE, with wb_cyc_i & wb_stb_i sampled high:
  - Decode: offset = wb_adr_i - BASE_ADDR.
  - Error case: if offset >= SIZE_BYTES, or wb_adr_i[log2(DATA_WIDTH/8)-1:0] != 0, go to ERR.
  - Write with wb_sel_i == 0: go to ACK. No downstream request is issued.
  - Otherwise, on the next edge:
    - rrq or wrq = 1 for exactly one cycle.
    - adr_o = offset >> 1.
    - tx_dat_o = wb_dat_i; tx_mask_o = ~wb_sel_i.
    - adr_o, tx_dat_o and tx_mask_o are held stable until the next request.
    - Go to READ (we=0) or WRITE (we=1). Timeout counter cleared.
- READ:
  - On rx_valid: wb_dat_o <= rx_dat_i, wb_ack_o <= 1, go to ACK.
  - Otherwise the counter increments.
- WRITE:
  - On tx_ready: wb_ack_o <= 1, go to ACK.
  - Otherwise the counter increments.
- Timeout: counter reaches TIMEOUT_CYCLES (nonzero) without a response → wb_err_o <= 1, timeout_o <= 1, go to DRAIN.
  - If the response arrives in the same cycle the limit is hit, the response wins (normal ack, no timeout).
- ACK: wb_ack_o high for exactly this one cycle; it clears and the state returns to IDLE on the next edge.
- ERR: wb_err_o high for exactly one cycle, then IDLE.
- DRAIN:
  - Ignore wb_stb_i; busy stays high.
  - Wait for the late rx_valid or tx_ready, discard it, then go to IDLE.
  - This prevents a stale response from being matched to a later request.
  - The timeout does not re-arm in DRAIN.
- Master abort: wb_cyc_i low while in READ/WRITE → go to DRAIN (no ack, no err). The outstanding downstream response is consumed there.
- Spurious input: rx_valid or tx_ready seen in IDLE/ACK/ERR is ignored.
- Request spacing: at most one request is outstanding; rrq/wrq are never issued while busy.
- wb_dat_o holds its last read value until the next read completes.
- Latency: wb_ack_o rises 1 cycle after rx_valid/tx_ready. rrq/wrq rise 1 cycle after the strobe is sampled.
- Reset mid-operation: return to IDLE immediately, all outputs 0. An in-flight downstream response arriving after reset is ignored.

Test Plan:
- Read 0x0000_0010 (BASE 0), rx_valid with rx_dat_i=0xDEADBEEF 5 cycles later → rrq pulse, adr_o=0x8, wb_ack_o one cycle after rx_valid, wb_dat_o=0xDEADBEEF.
- Write 0x0000_0100, data 0x12345678, sel=4'b0011, tx_ready after 3 cycles → wrq pulse, adr_o=0x80, tx_mask_o=4'b1100, tx_dat_o=0x12345678, single ack.
- Address 0x0080_0000 (out of window) and 0x0000_0002 (misaligned) → wb_err_o one cycle, no rrq/wrq.
- TIMEOUT_CYCLES=16, read with no response → wb_err_o and timeout_o at cycle 16. New strobe stalled until rx_valid at cycle 40, then a normal read succeeds with fresh data.
- wb_cyc_i dropped 2 cycles after wrq → no ack/err, busy until tx_ready, then IDLE. Write with sel=0 → immediate ack, no wrq.
- Back-to-back reads with stb held → exactly one rrq per ack. rx_valid in IDLE ignored. rst asserted in READ → all outputs 0 next cycle.

Source files
------------

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic slave that turns single-beat bus cycles into request pulses
// for the Hyperbus FIFO block, with window decode, alignment check and response timeout.
module hyperbus_wb_bridge #(
   parameter int unsigned              DATA_WIDTH     = 32,
   parameter int unsigned              ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR      = '0,
   parameter logic [ADDR_WIDTH-1:0]    SIZE_BYTES     = ADDR_WIDTH'(32'h0080_0000),
   parameter int unsigned              TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic                    wb_we_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic                    rrq,
   output logic                    wrq,
   output logic [ADDR_WIDTH-1:0]   adr_o,
   output logic [DATA_WIDTH-1:0]   tx_dat_o,
   output logic [DATA_WIDTH/8-1:0] tx_mask_o,
   input  logic                    tx_ready,
   input  logic [DATA_WIDTH-1:0]   rx_dat_i,
   input  logic                    rx_valid,
   output logic                    busy,
   output logic                    timeout_o
);

   localparam int unsigned SEL_WIDTH     = DATA_WIDTH / 8;
   localparam int unsigned BYTE_BITS     = $clog2(SEL_WIDTH);
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      ACK,
      ERR,
      DRAIN
   } state_t;

   state_t                  state_q, state_d;
   logic [15:0]             cnt_q, cnt_d;
   logic [15:0]             cnt_inc;
   logic                    rrq_q, rrq_d;
   logic                    wrq_q, wrq_d;
   logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [DATA_WIDTH-1:0]   tx_dat_q, tx_dat_d;
   logic [SEL_WIDTH-1:0]    tx_mask_q, tx_mask_d;
   logic [DATA_WIDTH-1:0]   wb_dat_q, wb_dat_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic                    timeout_q, timeout_d;

   logic [ADDR_WIDTH-1:0]   offset;
   logic                    out_of_window;
   logic                    misaligned;
   logic                    rsp_seen;

   assign offset        = wb_adr_i - BASE_ADDR;
   assign out_of_window = (offset >= SIZE_BYTES);
   assign misaligned    = (wb_adr_i[BYTE_BITS-1:0] != '0);
   assign cnt_inc       = cnt_q + 16'd1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rrq_d     = 1'b0;
      wrq_d     = 1'b0;
      adr_d     = adr_q;
      tx_dat_d  = tx_dat_q;
      tx_mask_d = tx_mask_q;
      wb_dat_d  = wb_dat_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      timeout_d = 1'b0;
      rsp_seen  = 1'b0;

      case (state_q)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               if (out_of_window || misaligned) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end else if (wb_we_i && (wb_sel_i == '0)) begin
                  ack_d   = 1'b1;
                  state_d = ACK;
               end else begin
                  rrq_d     = ~wb_we_i;
                  wrq_d     = wb_we_i;
                  adr_d     = offset >> 1;
                  tx_dat_d  = wb_dat_i;
                  tx_mask_d = ~wb_sel_i;
                  cnt_d     = '0;
                  state_d   = wb_we_i ? WRITE : READ;
               end
            end
         end

         READ, WRITE: begin
            rsp_seen = (state_q == READ) ? rx_valid : tx_ready;
            // A response that coincides with an abort is consumed here, so DRAIN never waits for it.
            if (rsp_seen) begin
               if (wb_cyc_i) begin
                  ack_d   = 1'b1;
                  state_d = ACK;
                  if (state_q == READ) begin
                     wb_dat_d = rx_dat_i;
                  end
               end else begin
                  state_d = IDLE;
               end
            end else if (!wb_cyc_i) begin
               state_d = DRAIN;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_LIMIT)) begin
               cnt_d     = cnt_inc;
               err_d     = 1'b1;
               timeout_d = 1'b1;
               state_d   = DRAIN;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ACK, ERR: begin
            state_d = IDLE;
         end

         DRAIN: begin
            if (rx_valid || tx_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rrq_q     <= 1'b0;
         wrq_q     <= 1'b0;
         adr_q     <= '0;
         tx_dat_q  <= '0;
         tx_mask_q <= '0;
         wb_dat_q  <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rrq_q     <= rrq_d;
         wrq_q     <= wrq_d;
         adr_q     <= adr_d;
         tx_dat_q  <= tx_dat_d;
         tx_mask_q <= tx_mask_d;
         wb_dat_q  <= wb_dat_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
      end
   end

   assign wb_dat_o  = wb_dat_q;
   assign wb_ack_o  = ack_q;
   assign wb_err_o  = err_q;
   assign rrq       = rrq_q;
   assign wrq       = wrq_q;
   assign adr_o     = adr_q;
   assign tx_dat_o  = tx_dat_q;
   assign tx_mask_o = tx_mask_q;
   assign busy      = (state_q != IDLE);
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Directed scoreboard bench for hyperbus_wb_bridge: stimulus queues the expected
// requests and bus responses, a negedge monitor pops and compares them.
module tb_hyperbus_wb_bridge;

   logic        clk;
   logic        rst;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        rrq;
   logic        wrq;
   logic [31:0] adr_o;
   logic [31:0] tx_dat_o;
   logic [3:0]  tx_mask_o;
   logic        tx_ready;
   logic [31:0] rx_dat_i;
   logic        rx_valid;
   logic        busy;
   logic        timeout_o;

   typedef struct {
      bit          is_wr;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  mask;
   } req_t;

   typedef struct {
      bit          is_err;
      bit          chk_dat;
      logic [31:0] dat;
      bit          tmo;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   req_t mon_req;
   rsp_t mon_rsp;
   int   total;
   int   bad;

   hyperbus_wb_bridge #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .BASE_ADDR      (32'h0000_0000),
      .SIZE_BYTES     (32'h0080_0000),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_adr_i  (wb_adr_i),
      .wb_dat_i  (wb_dat_i),
      .wb_sel_i  (wb_sel_i),
      .wb_we_i   (wb_we_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_stb_i  (wb_stb_i),
      .wb_dat_o  (wb_dat_o),
      .wb_ack_o  (wb_ack_o),
      .wb_err_o  (wb_err_o),
      .rrq       (rrq),
      .wrq       (wrq),
      .adr_o     (adr_o),
      .tx_dat_o  (tx_dat_o),
      .tx_mask_o (tx_mask_o),
      .tx_ready  (tx_ready),
      .rx_dat_i  (rx_dat_i),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .timeout_o (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleBus();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   // Presents a bus cycle and lets one edge sample it.
   task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      tick();
   endtask

   task automatic expectReq(input bit is_wr, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] mask);
      req_t r;
      r.is_wr = is_wr;
      r.adr   = adr;
      r.dat   = dat;
      r.mask  = mask;
      req_q.push_back(r);
   endtask

   task automatic expectRsp(input bit is_err, input bit chk_dat, input logic [31:0] dat, input bit tmo);
      rsp_t r;
      r.is_err  = is_err;
      r.chk_dat = chk_dat;
      r.dat     = dat;
      r.tmo     = tmo;
      rsp_q.push_back(r);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_wb_dat_o"}, wb_dat_o, 32'h0);
      checkOutput({tag, "_ack"}, 32'(wb_ack_o), 32'h0);
      checkOutput({tag, "_err"}, 32'(wb_err_o), 32'h0);
      checkOutput({tag, "_rrq_wrq"}, {30'b0, rrq, wrq}, 32'h0);
      checkOutput({tag, "_adr_o"}, adr_o, 32'h0);
      checkOutput({tag, "_tx_dat"}, tx_dat_o, 32'h0);
      checkOutput({tag, "_tx_mask"}, 32'(tx_mask_o), 32'h0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
      checkOutput({tag, "_timeout"}, 32'(timeout_o), 32'h0);
   endtask

   // Monitor: every request pulse and every ack/err cycle must match the next queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (rrq || wrq) begin
            checkOutput("req_expected", 32'(req_q.size() != 0), 32'd1);
            if (req_q.size() != 0) begin
               mon_req = req_q.pop_front();
               checkOutput("req_kind", {30'b0, rrq, wrq}, mon_req.is_wr ? 32'd1 : 32'd2);
               checkOutput("req_adr", adr_o, mon_req.adr);
               checkOutput("req_dat", tx_dat_o, mon_req.dat);
               checkOutput("req_mask", 32'(tx_mask_o), 32'(mon_req.mask));
               checkOutput("req_busy", 32'(busy), 32'd1);
            end
         end
         if (wb_ack_o || wb_err_o) begin
            checkOutput("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            if (rsp_q.size() != 0) begin
               mon_rsp = rsp_q.pop_front();
               checkOutput("rsp_kind", {30'b0, wb_ack_o, wb_err_o}, mon_rsp.is_err ? 32'd1 : 32'd2);
               checkOutput("rsp_timeout", 32'(timeout_o), 32'(mon_rsp.tmo));
               if (mon_rsp.chk_dat) begin
                  checkOutput("rsp_dat", wb_dat_o, mon_rsp.dat);
               end
            end
         end else if (timeout_o) begin
            checkOutput("timeout_without_err", 32'(timeout_o), 32'd0);
         end
      end
   end

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_sel_i = '0;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_dat_i = '0;
      idleBus();
      repeat (3) tick();
      checkAllZero("reset");
      rst = 1'b0;
      tick();

      $display("[TB] read 0x10, rx_valid 5 cycles after request");
      expectReq(1'b0, 32'h8, 32'h0, 4'h0);
      expectRsp(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'hF);
      repeat (2) tick();
      checkOutput("read_wait_busy", 32'(busy), 32'd1);
      checkOutput("read_wait_ack", 32'(wb_ack_o), 32'd0);
      repeat (2) tick();
      rx_valid = 1'b1;
      rx_dat_i = 32'hDEAD_BEEF;
      tick();
      rx_valid = 1'b0;
      rx_dat_i = '0;
      idleBus();
      repeat (2) tick();

      $display("[TB] write 0x100 sel 0011, tx_ready after 3 cycles");
      expectReq(1'b1, 32'h80, 32'h1234_5678, 4'b1100);
      expectRsp(1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
      repeat (2) tick();
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      idleBus();
      repeat (2) tick();
      checkOutput("write_adr_held", adr_o, 32'h80);
      checkOutput("write_mask_held", 32'(tx_mask_o), 32'hC);
      checkOutput("write_dat_held", tx_dat_o, 32'h1234_5678);
      checkOutput("rdata_held_after_write", wb_dat_o, 32'hDEAD_BEEF);

      $display("[TB] out-of-window and misaligned addresses");
      expectRsp(1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0080_0000, 32'h0, 4'hF);
      idleBus();
      repeat (2) tick();
      expectRsp(1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0002, 32'h1111_2222, 4'hF);
      idleBus();
      repeat (2) tick();
      expectRsp(1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h007F_FFFD, 32'h0, 4'hF);
      idleBus();
      repeat (2) tick();

      $display("[TB] last aligned word of the window");
      expectReq(1'b0, 32'h003F_FFFE, 32'h0, 4'h0);
      expectRsp(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0);
      applyStimulus(1'b0, 32'h007F_FFFC, 32'h0, 4'hF);
      rx_valid = 1'b1;
      rx_dat_i = 32'h0BAD_F00D;
      tick();
      rx_valid = 1'b0;
      idleBus();
      repeat (2) tick();

      $display("[TB] read timeout, stalled strobe, stale response drained");
      expectReq(1'b0, 32'h10, 32'h0, 4'h0);
      expectRsp(1'b1, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4'hF);
      repeat (15) tick();
      checkOutput("before_timeout_err", 32'(wb_err_o), 32'd0);
      tick();
      wb_adr_i = 32'h0000_0040;
      repeat (23) tick();
      checkOutput("drain_busy", 32'(busy), 32'd1);
      checkOutput("drain_no_rrq", 32'(rrq), 32'd0);
      rx_valid = 1'b1;
      rx_dat_i = 32'hBAD0_BAD0;
      tick();
      rx_valid = 1'b0;
      rx_dat_i = '0;
      checkOutput("drain_done_idle", 32'(busy), 32'd0);
      expectReq(1'b0, 32'h20, 32'h0, 4'h0);
      expectRsp(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
      tick();
      repeat (2) tick();
      rx_valid = 1'b1;
      rx_dat_i = 32'hCAFE_F00D;
      tick();
      rx_valid = 1'b0;
      idleBus();
      repeat (2) tick();

      $display("[TB] master abort during write");
      expectReq(1'b1, 32'h100, 32'hA5A5_5A5A, 4'h0);
      applyStimulus(1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 4'hF);
      repeat (2) tick();
      idleBus();
      repeat (4) tick();
      checkOutput("abort_busy", 32'(busy), 32'd1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      checkOutput("abort_idle", 32'(busy), 32'd0);
      tick();

      $display("[TB] write with empty byte select");
      expectRsp(1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0300, 32'h7777_7777, 4'h0);
      idleBus();
      repeat (2) tick();
      checkOutput("sel0_adr_unchanged", adr_o, 32'h100);

      $display("[TB] back-to-back reads with strobe held");
      for (int i = 0; i < 3; i++) begin
         expectReq(1'b0, 32'h18, 32'h0, 4'h0);
         expectRsp(1'b0, 1'b1, 32'h1000_0000 + 32'(i), 1'b0);
      end
      applyStimulus(1'b0, 32'h0000_0030, 32'h0, 4'hF);
      for (int i = 0; i < 3; i++) begin
         tick();
         rx_valid = 1'b1;
         rx_dat_i = 32'h1000_0000 + 32'(i);
         tick();
         rx_valid = 1'b0;
         if (i == 2) begin
            idleBus();
         end
         repeat (2) tick();
      end

      $display("[TB] spurious rx_valid in idle");
      rx_valid = 1'b1;
      rx_dat_i = 32'h5555_5555;
      tick();
      rx_valid = 1'b0;
      checkOutput("spurious_ack", 32'(wb_ack_o), 32'd0);
      checkOutput("spurious_busy", 32'(busy), 32'd0);
      checkOutput("spurious_rdata", wb_dat_o, 32'h1000_0002);
      tick();

      $display("[TB] reset while in READ");
      expectReq(1'b0, 32'h22, 32'h0, 4'h0);
      applyStimulus(1'b0, 32'h0000_0044, 32'h0, 4'hF);
      tick();
      rst = 1'b1;
      idleBus();
      tick();
      checkAllZero("midop_reset");
      rst = 1'b0;
      rx_valid = 1'b1;
      rx_dat_i = 32'h9999_9999;
      tick();
      rx_valid = 1'b0;
      checkOutput("late_rsp_ack", 32'(wb_ack_o), 32'd0);
      checkOutput("late_rsp_busy", 32'(busy), 32'd0);
      checkOutput("late_rsp_rdata", wb_dat_o, 32'h0);
      repeat (2) tick();

      checkOutput("req_queue_left", 32'(req_q.size()), 32'd0);
      checkOutput("rsp_queue_left", 32'(rsp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
